// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the port arbiter and the shared SRAM-like port.
// The master view belongs to the arbiter; the slave view belongs to the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          inst_req;
   logic [AW-1:0] inst_addr;
   logic          inst_adv;
   logic [DW-1:0] inst_rdata;
   logic          stallreq_from_if;

   logic          data_req;
   logic          data_wr;
   logic [1:0]    data_size;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_wdata;
   logic [3:0]    data_sel;
   logic          data_adv;
   logic [DW-1:0] data_rdata;
   logic          stallreq_from_mem;

   logic          bus_req;
   logic          bus_wr;
   logic [1:0]    bus_size;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [3:0]    bus_sel;
   logic          bus_addr_ok;
   logic          bus_data_ok;
   logic [DW-1:0] bus_rdata;

   modport master (
      input  inst_req, inst_addr, inst_adv,
      output inst_rdata, stallreq_from_if,
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_sel, data_adv,
      output data_rdata, stallreq_from_mem,
      output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_sel,
      input  bus_addr_ok, bus_data_ok, bus_rdata
   );

   modport slave (
      output inst_req, inst_addr, inst_adv,
      input  inst_rdata, stallreq_from_if,
      output data_req, data_wr, data_size, data_addr, data_wdata, data_sel, data_adv,
      input  data_rdata, stallreq_from_mem,
      input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_sel,
      output bus_addr_ok, bus_data_ok, bus_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data accesses, one transaction
// at a time, with data having priority; returned words are held until the owning stage advances.
module mem_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.master mp
);
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

   state_t        state_q, state_d;
   logic          owner_data_q;
   logic          inst_served_q, data_served_q;
   logic          bus_req_q, bus_wr_q;
   logic [1:0]    bus_size_q;
   logic [AW-1:0] bus_addr_q;
   logic [DW-1:0] bus_wdata_q;
   logic [3:0]    bus_sel_q;
   logic [DW-1:0] inst_rdata_q, data_rdata_q;
   logic          grant_data, grant_inst;
   logic          done, done_inst, done_data;

   always_comb begin
      state_d    = state_q;
      grant_data = 1'b0;
      grant_inst = 1'b0;
      case (state_q)
         IDLE: begin
            grant_data = mp.data_req & ~data_served_q;
            grant_inst = ~grant_data & mp.inst_req & ~inst_served_q;
            if (grant_data | grant_inst) state_d = ADDR;
         end
         ADDR:    if (mp.bus_addr_ok) state_d = DATA;
         DATA:    if (mp.bus_data_ok) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A response only counts in DATA; data_ok seen while still in ADDR is ignored.
   assign done      = (state_q == DATA) & mp.bus_data_ok;
   assign done_inst = done & ~owner_data_q;
   assign done_data = done & owner_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_data_q <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_size_q   <= 2'd0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_sel_q    <= 4'd0;
      end else if (grant_data) begin
         owner_data_q <= 1'b1;
         bus_req_q    <= 1'b1;
         bus_wr_q     <= mp.data_wr;
         bus_size_q   <= mp.data_size;
         bus_addr_q   <= mp.data_addr;
         bus_wdata_q  <= mp.data_wdata;
         bus_sel_q    <= mp.data_sel;
      end else if (grant_inst) begin
         owner_data_q <= 1'b0;
         bus_req_q    <= 1'b1;
         bus_wr_q     <= 1'b0;
         bus_size_q   <= 2'd2;
         bus_addr_q   <= mp.inst_addr;
         bus_wdata_q  <= '0;
         bus_sel_q    <= 4'hF;
      end else if ((state_q == ADDR) && mp.bus_addr_ok) begin
         bus_req_q    <= 1'b0;
      end
   end

   // Served flags block re-issue until the stage advances; a requester that let go gets nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_served_q <= 1'b0;
         data_served_q <= 1'b0;
         inst_rdata_q  <= '0;
         data_rdata_q  <= '0;
      end else begin
         if (mp.inst_adv)                    inst_served_q <= 1'b0;
         else if (done_inst & mp.inst_req)   inst_served_q <= 1'b1;
         if (mp.data_adv)                    data_served_q <= 1'b0;
         else if (done_data & mp.data_req)   data_served_q <= 1'b1;
         if (done_inst & mp.inst_req)             inst_rdata_q <= mp.bus_rdata;
         if (done_data & mp.data_req & ~bus_wr_q) data_rdata_q <= mp.bus_rdata;
      end
   end

   assign mp.stallreq_from_if  = mp.inst_req & ~inst_served_q & ~done_inst;
   assign mp.stallreq_from_mem = mp.data_req & ~data_served_q & ~done_data;
   assign mp.inst_rdata        = done_inst ? mp.bus_rdata : inst_rdata_q;
   assign mp.data_rdata        = (done_data & ~bus_wr_q) ? mp.bus_rdata : data_rdata_q;

   assign mp.bus_req   = bus_req_q;
   assign mp.bus_wr    = bus_wr_q;
   assign mp.bus_size  = bus_size_q;
   assign mp.bus_addr  = bus_addr_q;
   assign mp.bus_wdata = bus_wdata_q;
   assign mp.bus_sel   = bus_sel_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized requesters and a
// randomized memory responder, checked against a transaction-level model of both stages.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [31:0] mem_img [logic [31:0]];

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) mp();
   mem_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .mp(mp));

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running at %0t, limit 800000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic clear_inputs();
      mp.inst_req = 1'b0; mp.inst_addr = '0; mp.inst_adv = 1'b0;
      mp.data_req = 1'b0; mp.data_wr = 1'b0; mp.data_size = 2'd0; mp.data_addr = '0;
      mp.data_wdata = '0; mp.data_sel = 4'd0; mp.data_adv = 1'b0;
      mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b0; mp.bus_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      tick(); tick(); settle();
      n_checks++;
      if ({mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel} !== 8'h00 || mp.bus_addr !== 32'h0 || mp.bus_wdata !== 32'h0)
         $display("FAIL reset_bus: req/wr/size/sel=%h addr=%h wdata=%h, want all 0",
                  {mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel}, mp.bus_addr, mp.bus_wdata);
      else n_pass++;
      n_checks++;
      if (mp.inst_rdata !== 32'h0 || mp.data_rdata !== 32'h0)
         $display("FAIL reset_rdata: inst=%h data=%h, want 0", mp.inst_rdata, mp.data_rdata);
      else n_pass++;
      n_checks++;
      if ({mp.stallreq_from_if, mp.stallreq_from_mem} !== 2'b00)
         $display("FAIL reset_stall: got %b want 00", {mp.stallreq_from_if, mp.stallreq_from_mem});
      else n_pass++;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      tick(); mp.inst_req = 1'b1; mp.inst_addr = 32'hBFC00000; settle();
      n_checks++;
      if ({mp.stallreq_from_if, mp.bus_req} !== 2'b10)
         $display("FAIL fetch_c0: stall/bus_req=%b want 10", {mp.stallreq_from_if, mp.bus_req});
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b1; settle();
      n_checks++;
      if ({mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel} !== {1'b1, 1'b0, 2'd2, 4'hF} ||
          mp.bus_addr !== 32'hBFC00000 || mp.stallreq_from_if !== 1'b1)
         $display("FAIL fetch_c1_cmd: req/wr/size/sel=%h addr=%h stall=%b, want af bfc00000 1",
                  {mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel}, mp.bus_addr, mp.stallreq_from_if);
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b1; mp.bus_rdata = 32'h3C080001; settle();
      n_checks++;
      if (mp.stallreq_from_if !== 1'b0 || mp.inst_rdata !== 32'h3C080001 || mp.bus_req !== 1'b0)
         $display("FAIL fetch_c2_done: stall=%b rdata=%h bus_req=%b, want 0 3c080001 0",
                  mp.stallreq_from_if, mp.inst_rdata, mp.bus_req);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         tick(); mp.bus_data_ok = 1'b0; mp.bus_rdata = $urandom; mp.inst_adv = (k == 2); settle();
         n_checks++;
         if (mp.stallreq_from_if !== 1'b0 || mp.inst_rdata !== 32'h3C080001 || mp.bus_req !== 1'b0)
            $display("FAIL fetch_hold%0d: stall=%b rdata=%h bus_req=%b, want 0 3c080001 0",
                     k, mp.stallreq_from_if, mp.inst_rdata, mp.bus_req);
         else n_pass++;
      end
      tick(); mp.inst_req = 1'b0; mp.inst_adv = 1'b0;
   endtask

   task automatic test_priority();
      tick();
      mp.data_req = 1'b1; mp.data_wr = 1'b0; mp.data_size = 2'd2; mp.data_addr = 32'h80001000;
      mp.data_sel = 4'hF; mp.data_wdata = 32'h0;
      mp.inst_req = 1'b1; mp.inst_addr = 32'hBFC00004;
      settle();
      n_checks++;
      if ({mp.stallreq_from_if, mp.stallreq_from_mem} !== 2'b11)
         $display("FAIL prio_c0_stall: got %b want 11", {mp.stallreq_from_if, mp.stallreq_from_mem});
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b1; settle();
      n_checks++;
      if (mp.bus_req !== 1'b1 || mp.bus_addr !== 32'h80001000 || mp.bus_wr !== 1'b0)
         $display("FAIL prio_first_cmd: req=%b addr=%h wr=%b, want 1 80001000 0", mp.bus_req, mp.bus_addr, mp.bus_wr);
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b1; mp.bus_rdata = 32'h11223344; settle();
      n_checks++;
      if ({mp.stallreq_from_if, mp.stallreq_from_mem} !== 2'b10 || mp.data_rdata !== 32'h11223344)
         $display("FAIL prio_load_done: stalls=%b data_rdata=%h, want 10 11223344",
                  {mp.stallreq_from_if, mp.stallreq_from_mem}, mp.data_rdata);
      else n_pass++;
      tick(); mp.bus_data_ok = 1'b0; mp.bus_rdata = 32'h0; mp.data_adv = 1'b1; settle();
      n_checks++;
      if (mp.bus_req !== 1'b0 || mp.stallreq_from_if !== 1'b1 || mp.data_rdata !== 32'h11223344)
         $display("FAIL prio_gap: bus_req=%b stall_if=%b data_rdata=%h, want 0 1 11223344",
                  mp.bus_req, mp.stallreq_from_if, mp.data_rdata);
      else n_pass++;
      tick(); mp.data_req = 1'b0; mp.data_adv = 1'b0; mp.bus_addr_ok = 1'b1; settle();
      n_checks++;
      if (mp.bus_req !== 1'b1 || mp.bus_addr !== 32'hBFC00004 || mp.stallreq_from_if !== 1'b1)
         $display("FAIL prio_fetch_cmd: req=%b addr=%h stall_if=%b, want 1 bfc00004 1",
                  mp.bus_req, mp.bus_addr, mp.stallreq_from_if);
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b1; mp.bus_rdata = 32'hAABBCCDD; settle();
      n_checks++;
      if (mp.stallreq_from_if !== 1'b0 || mp.inst_rdata !== 32'hAABBCCDD)
         $display("FAIL prio_fetch_done: stall_if=%b rdata=%h, want 0 aabbccdd", mp.stallreq_from_if, mp.inst_rdata);
      else n_pass++;
      tick(); mp.bus_data_ok = 1'b0; mp.inst_adv = 1'b1;
      tick(); mp.inst_req = 1'b0; mp.inst_adv = 1'b0;
   endtask

   task automatic test_store();
      int n_req_cycles;
      n_req_cycles = 0;
      tick();
      mp.data_req = 1'b1; mp.data_wr = 1'b1; mp.data_size = 2'd2; mp.data_addr = 32'h80002000;
      mp.data_wdata = 32'hDEADBEEF; mp.data_sel = 4'hF;
      settle();
      tick(); mp.bus_addr_ok = 1'b1; settle();
      n_checks++;
      if ({mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel} !== {1'b1, 1'b1, 2'd2, 4'hF} ||
          mp.bus_addr !== 32'h80002000 || mp.bus_wdata !== 32'hDEADBEEF)
         $display("FAIL store_cmd: req/wr/size/sel=%h addr=%h wdata=%h, want ef 80002000 deadbeef",
                  {mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel}, mp.bus_addr, mp.bus_wdata);
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b1; settle();
      n_checks++;
      if (mp.stallreq_from_mem !== 1'b0)
         $display("FAIL store_done_stall: got %b want 0", mp.stallreq_from_mem);
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         tick(); mp.bus_data_ok = 1'b0; mp.data_adv = (k == 3); mp.data_req = (k < 4); settle();
         if (mp.bus_req) n_req_cycles++;
      end
      n_checks++;
      if (n_req_cycles !== 0)
         $display("FAIL store_no_reissue: %0d extra bus_req cycles, want 0", n_req_cycles);
      else n_pass++;
      mp.data_wr = 1'b0;
   endtask

   task automatic test_addr_delay();
      tick(); mp.inst_req = 1'b1; mp.inst_addr = 32'hBFC00010;
      for (int k = 1; k <= 5; k++) begin
         tick(); mp.bus_addr_ok = (k == 5); mp.bus_data_ok = (k == 2); mp.bus_rdata = $urandom; settle();
         n_checks++;
         if ({mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel} !== {1'b1, 1'b0, 2'd2, 4'hF} ||
             mp.bus_addr !== 32'hBFC00010 || mp.stallreq_from_if !== 1'b1)
            $display("FAIL addr_wait%0d: req/wr/size/sel=%h addr=%h stall=%b, want af bfc00010 1",
                     k, {mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel}, mp.bus_addr, mp.stallreq_from_if);
         else n_pass++;
      end
      tick(); mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b1; mp.bus_rdata = 32'h12345678; settle();
      n_checks++;
      if (mp.stallreq_from_if !== 1'b0 || mp.inst_rdata !== 32'h12345678 || mp.bus_req !== 1'b0)
         $display("FAIL addr_wait_done: stall=%b rdata=%h bus_req=%b, want 0 12345678 0",
                  mp.stallreq_from_if, mp.inst_rdata, mp.bus_req);
      else n_pass++;
      tick(); mp.bus_data_ok = 1'b0; mp.inst_adv = 1'b1;
      tick(); mp.inst_req = 1'b0; mp.inst_adv = 1'b0;
   endtask

   task automatic test_reset_mid();
      tick(); mp.inst_req = 1'b1; mp.inst_addr = 32'hBFC00020;
      tick(); mp.bus_addr_ok = 1'b1;
      tick(); mp.bus_addr_ok = 1'b0; mp.inst_req = 1'b0; rst = 1'b1;
      tick(); rst = 1'b0; settle();
      n_checks++;
      if ({mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel} !== 8'h00 || mp.bus_addr !== 32'h0 ||
          mp.inst_rdata !== 32'h0 || mp.data_rdata !== 32'h0 ||
          {mp.stallreq_from_if, mp.stallreq_from_mem} !== 2'b00)
         $display("FAIL reset_mid: bus=%h addr=%h irdata=%h drdata=%h stalls=%b, want all 0",
                  {mp.bus_req, mp.bus_wr, mp.bus_size, mp.bus_sel}, mp.bus_addr, mp.inst_rdata,
                  mp.data_rdata, {mp.stallreq_from_if, mp.stallreq_from_mem});
      else n_pass++;
      tick(); mp.inst_req = 1'b1; mp.inst_addr = 32'hBFC00024;
      tick(); mp.bus_addr_ok = 1'b1; settle();
      n_checks++;
      if (mp.bus_req !== 1'b1 || mp.bus_addr !== 32'hBFC00024)
         $display("FAIL reset_refetch_cmd: req=%b addr=%h, want 1 bfc00024", mp.bus_req, mp.bus_addr);
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b1; mp.bus_rdata = 32'h0BADF00D; settle();
      n_checks++;
      if (mp.stallreq_from_if !== 1'b0 || mp.inst_rdata !== 32'h0BADF00D)
         $display("FAIL reset_refetch_done: stall=%b rdata=%h, want 0 0badf00d", mp.stallreq_from_if, mp.inst_rdata);
      else n_pass++;
      tick(); mp.bus_data_ok = 1'b0; mp.inst_adv = 1'b1;
      tick(); mp.inst_req = 1'b0; mp.inst_adv = 1'b0;
   endtask

   task automatic test_drop();
      tick(); mp.inst_req = 1'b1; mp.inst_addr = 32'hBFC00030;
      tick(); mp.bus_addr_ok = 1'b1;
      tick(); mp.bus_addr_ok = 1'b0; mp.inst_req = 1'b0;
      tick(); mp.bus_data_ok = 1'b1; mp.bus_rdata = 32'h55555555; settle();
      n_checks++;
      if (mp.stallreq_from_if !== 1'b0)
         $display("FAIL drop_stall: got %b want 0", mp.stallreq_from_if);
      else n_pass++;
      tick(); mp.bus_data_ok = 1'b0; mp.inst_req = 1'b1; mp.inst_addr = 32'hBFC00034; settle();
      n_checks++;
      if (mp.stallreq_from_if !== 1'b1 || mp.inst_rdata !== 32'h0BADF00D)
         $display("FAIL drop_not_served: stall=%b rdata=%h, want 1 0badf00d", mp.stallreq_from_if, mp.inst_rdata);
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b1; settle();
      n_checks++;
      if (mp.bus_req !== 1'b1 || mp.bus_addr !== 32'hBFC00034)
         $display("FAIL drop_new_cmd: req=%b addr=%h, want 1 bfc00034", mp.bus_req, mp.bus_addr);
      else n_pass++;
      tick(); mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b1; mp.bus_rdata = 32'h66666666; settle();
      n_checks++;
      if (mp.stallreq_from_if !== 1'b0 || mp.inst_rdata !== 32'h66666666)
         $display("FAIL drop_new_done: stall=%b rdata=%h, want 0 66666666", mp.stallreq_from_if, mp.inst_rdata);
      else n_pass++;
      tick(); mp.bus_data_ok = 1'b0; mp.inst_adv = 1'b1;
      tick(); mp.inst_req = 1'b0; mp.inst_adv = 1'b0;
   endtask

   // Each stage holds one request at a time; the memory answers with random latency from mem_img.
   task automatic test_random();
      bit i_act = 0, i_done = 0, i_leave = 0, d_act = 0, d_done = 0, d_leave = 0;
      bit resp_pend = 0, resp_inst = 0, prev_breq = 0, prev_dpend = 0, abort = 0;
      int i_issued = 0, i_wait = 0, i_hold = 0, d_issued = 0, d_wait = 0, d_hold = 0;
      logic [31:0] i_addr = 0, i_exp = 0, d_addr = 0, d_wdata = 0, d_exp = 0, resp_val = 0;
      logic        d_wr = 0;
      logic [1:0]  d_size = 0;
      logic [3:0]  d_sel = 0;
      rst = 1'b1; clear_inputs(); tick(); tick(); rst = 1'b0;
      for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
         tick();
         mp.inst_adv = 1'b0;
         if (i_leave) begin
            i_leave = 0; i_act = 0;
            n_checks++;
            if (i_issued !== 1) $display("FAIL rand_fetch_count: addr %h issued %0d times, want 1", i_addr, i_issued);
            else n_pass++;
         end
         if (!i_act) begin
            mp.inst_adv = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 2) == 0) begin
               i_act = 1; i_done = 0; i_issued = 0; i_wait = 0; i_hold = $urandom_range(0, 3);
               i_addr = 32'hBFC00000 | ($urandom_range(0, 255) << 2);
            end
         end else if (i_done) begin
            if (i_hold == 0) begin mp.inst_adv = 1'b1; i_leave = 1; end
            else i_hold--;
         end else if (++i_wait > 400) begin
            n_checks++; abort = 1;
            $display("FAIL rand_fetch_timeout: addr %h still stalled after %0d cycles, limit 400", i_addr, i_wait);
         end
         mp.inst_req = i_act; mp.inst_addr = i_addr;

         mp.data_adv = 1'b0;
         if (d_leave) begin
            d_leave = 0; d_act = 0;
            n_checks++;
            if (d_issued !== 1) $display("FAIL rand_data_count: addr %h wr %b issued %0d times, want 1", d_addr, d_wr, d_issued);
            else n_pass++;
         end
         if (!d_act) begin
            mp.data_adv = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 2) == 0) begin
               d_act = 1; d_done = 0; d_issued = 0; d_wait = 0; d_hold = $urandom_range(0, 3);
               d_wr = ($urandom_range(0, 2) == 0); d_addr = 32'h80001000 | ($urandom_range(0, 15) << 2);
               d_wdata = $urandom; d_size = 2'($urandom_range(0, 2)); d_sel = 4'($urandom_range(0, 15));
            end
         end else if (d_done) begin
            if (d_hold == 0) begin mp.data_adv = 1'b1; d_leave = 1; end
            else d_hold--;
         end else if (++d_wait > 400) begin
            n_checks++; abort = 1;
            $display("FAIL rand_data_timeout: addr %h still stalled after %0d cycles, limit 400", d_addr, d_wait);
         end
         mp.data_req = d_act; mp.data_wr = d_wr; mp.data_addr = d_addr; mp.data_wdata = d_wdata;
         mp.data_size = d_size; mp.data_sel = d_sel;

         if (mp.bus_req && !prev_breq && prev_dpend) begin
            n_checks++;
            if (mp.bus_addr[31:28] !== 4'h8) $display("FAIL rand_priority: bus_addr=%h, want data address %h", mp.bus_addr, d_addr);
            else n_pass++;
         end
         prev_breq  = mp.bus_req;
         prev_dpend = d_act && !d_done && (d_issued == 0);

         mp.bus_addr_ok = 1'b0; mp.bus_data_ok = 1'b0; mp.bus_rdata = $urandom;
         if (resp_pend) begin
            if ($urandom_range(0, 1) == 0) begin
               mp.bus_data_ok = 1'b1; mp.bus_rdata = resp_val; resp_pend = 0;
               if (resp_inst) begin i_done = 1; i_exp = resp_val; end
               else begin d_done = 1; d_exp = resp_val; end
            end
         end else if (mp.bus_req && $urandom_range(0, 2) != 0) begin
            mp.bus_addr_ok = 1'b1; resp_pend = 1; resp_inst = (mp.bus_addr[31:28] == 4'hB);
            n_checks++;
            if (resp_inst) begin
               i_issued++;
               if ({mp.bus_wr, mp.bus_size, mp.bus_sel, mp.bus_addr} !== {1'b0, 2'd2, 4'hF, i_addr} || !i_act)
                  $display("FAIL rand_fetch_cmd: wr/size/sel=%h addr=%h, want 2f %h", {mp.bus_wr, mp.bus_size, mp.bus_sel}, mp.bus_addr, i_addr);
               else n_pass++;
               resp_val = mem_img.exists(i_addr) ? mem_img[i_addr] : i_addr * 32'h9E3779B1;
            end else begin
               d_issued++;
               if ({mp.bus_wr, mp.bus_size, mp.bus_sel, mp.bus_addr, mp.bus_wdata} !== {d_wr, d_size, d_sel, d_addr, d_wdata} || !d_act)
                  $display("FAIL rand_data_cmd: wr/size/sel=%h addr=%h wdata=%h, want %h %h %h",
                           {mp.bus_wr, mp.bus_size, mp.bus_sel}, mp.bus_addr, mp.bus_wdata, {d_wr, d_size, d_sel}, d_addr, d_wdata);
               else n_pass++;
               if (d_wr) begin mem_img[d_addr] = d_wdata; resp_val = $urandom; end
               else resp_val = mem_img.exists(d_addr) ? mem_img[d_addr] : d_addr * 32'h9E3779B1;
            end
         end

         settle();
         n_checks++;
         if ({mp.stallreq_from_if, mp.stallreq_from_mem} !== {i_act & ~i_done, d_act & ~d_done})
            $display("FAIL rand_stall: cycle %0d got %b want %b", cyc,
                     {mp.stallreq_from_if, mp.stallreq_from_mem}, {i_act & ~i_done, d_act & ~d_done});
         else n_pass++;
         if (i_act && i_done) begin
            n_checks++;
            if (mp.inst_rdata !== i_exp) $display("FAIL rand_inst_rdata: cycle %0d got %h want %h", cyc, mp.inst_rdata, i_exp);
            else n_pass++;
         end
         if (d_act && d_done && !d_wr) begin
            n_checks++;
            if (mp.data_rdata !== d_exp) $display("FAIL rand_data_rdata: cycle %0d got %h want %h", cyc, mp.data_rdata, d_exp);
            else n_pass++;
         end
      end
      clear_inputs();
      tick(); tick();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_fetch();
      test_priority();
      test_store();
      test_addr_delay();
      test_reset_mid();
      test_drop();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
